// File: rtl/sfp_ctrl.sv
// sfp_ctrl: walks the psum memory output by output, steering the sfp accumulator and
// writing each ReLU result back; every output costs NUM_ACC reads, one wait and one write.
module sfp_ctrl #(
  parameter int NUM_ACC  = 9,
  parameter int NUM_OUT  = 16,
  parameter int ADDR_BW  = 8,
  parameter int OADDR_BW = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  output logic                ren,
  output logic [ADDR_BW-1:0]  raddr,
  output logic                acc,
  output logic                wen,
  output logic [OADDR_BW-1:0] waddr,
  output logic                busy,
  output logic                done
);
  localparam int KW = NUM_ACC > 1 ? $clog2(NUM_ACC) : 1;
  localparam logic [KW-1:0] k_last = KW'(NUM_ACC - 1);
  localparam logic [OADDR_BW-1:0] o_last = OADDR_BW'(NUM_OUT - 1);
  typedef enum logic [2:0] {IDLE, RUN, WAIT, WRITE, DONE} state_t;
  state_t state;
  logic [KW-1:0] k;
  logic [OADDR_BW-1:0] o;
  logic rv;
  assign acc = rv;
  // rv mirrors ren one cycle late, so acc lines up with the memory's read latency
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      k     <= '0;
      o     <= '0;
      rv    <= 1'b0;
      ren   <= 1'b0;
      raddr <= '0;
      wen   <= 1'b0;
      waddr <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      rv   <= ren;
      wen  <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE:
          if (start) begin
            state <= RUN;
            k     <= '0;
            o     <= '0;
            ren   <= 1'b1;
            raddr <= '0;
            busy  <= 1'b1;
          end
        RUN:
          if (k == k_last) begin
            state <= WAIT;
            ren   <= 1'b0;
          end else begin
            k     <= k + 1'b1;
            raddr <= raddr + ADDR_BW'(NUM_OUT);
          end
        WAIT: begin
          state <= WRITE;
          wen   <= 1'b1;
          waddr <= o;
        end
        WRITE:
          if (o == o_last) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            state <= RUN;
            o     <= o + 1'b1;
            k     <= '0;
            ren   <= 1'b1;
            raddr <= ADDR_BW'(o) + ADDR_BW'(1);
          end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_sfp_ctrl.sv
// tb_sfp_ctrl: scoreboarded bench with a 1-cycle psum memory and an sfp accumulator/ReLU model.
module tb_sfp_ctrl;
  logic clk = 1'b0;
  logic reset, start0, start1;
  logic ren0, acc0, wen0, busy0, done0;
  logic [7:0] raddr0;
  logic [3:0] waddr0;
  logic ren1, acc1, wen1, busy1, done1;
  logic [7:0] raddr1;
  logic [3:0] waddr1;
  int errs = 0;
  int checks = 0;
  int pm [6] = '{5, -3, -2, 1, 4, 1};
  int rdata = 0;
  int sum;
  int relu;
  int rq[$];
  int wa_q[$];
  int wd_q[$];

  always #5 clk = ~clk;

  sfp_ctrl #(.NUM_ACC(3), .NUM_OUT(2), .ADDR_BW(8), .OADDR_BW(4)) u0 (
    .clk(clk), .reset(reset), .start(start0), .ren(ren0), .raddr(raddr0), .acc(acc0),
    .wen(wen0), .waddr(waddr0), .busy(busy0), .done(done0));

  sfp_ctrl #(.NUM_ACC(1), .NUM_OUT(4), .ADDR_BW(8), .OADDR_BW(4)) u1 (
    .clk(clk), .reset(reset), .start(start1), .ren(ren1), .raddr(raddr1), .acc(acc1),
    .wen(wen1), .waddr(waddr1), .busy(busy1), .done(done1));

  always @(posedge clk) if (ren0) rdata <= pm[raddr0];

  always @(posedge clk or posedge reset)
    if (reset) sum <= 0;
    else sum <= acc0 ? sum + rdata : 0;

  assign relu = sum < 0 ? 0 : sum;

  always @(negedge clk) begin
    if (ren0) begin
      checks++;
      if (wen0) begin
        errs++;
        $display("FAIL ren_wen_overlap: ren=%0b wen=%0b required not both", ren0, wen0);
      end else if (rq.size() == 0) begin
        errs++;
        $display("FAIL raddr: unexpected read of %0d, required none", raddr0);
      end else begin
        int e;
        e = rq.pop_front();
        if (raddr0 !== 8'(e)) begin
          errs++;
          $display("FAIL raddr: got %0d required %0d", raddr0, e);
        end
      end
    end
    if (wen0) begin
      checks++;
      if (wa_q.size() == 0) begin
        errs++;
        $display("FAIL write: unexpected write waddr=%0d data=%0d, required none", waddr0, relu);
      end else begin
        int ea, ed;
        ea = wa_q.pop_front();
        ed = wd_q.pop_front();
        if (waddr0 !== 4'(ea) || relu !== ed) begin
          errs++;
          $display("FAIL write: got waddr=%0d data=%0d required waddr=%0d data=%0d",
                   waddr0, relu, ea, ed);
        end
      end
    end
  end

  task automatic push_run();
    for (int o = 0; o < 2; o++) begin
      int s;
      s = 0;
      for (int k = 0; k < 3; k++) begin
        rq.push_back(k * 2 + o);
        s += pm[k * 2 + o];
      end
      wa_q.push_back(o);
      wd_q.push_back(s < 0 ? 0 : s);
    end
  endtask

  task automatic do_start0();
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
  endtask

  task automatic run_check(input string name, input int pulse_at, input bit chain);
    int cyc, nacc, nidle;
    cyc = 1;
    nacc = 0;
    nidle = 0;
    push_run();
    while (!done0 && cyc < 40) begin
      if (!busy0) nidle++;
      if (acc0) nacc++;
      start0 = (cyc == pulse_at);
      @(posedge clk); #1;
      cyc++;
    end
    start0 = 1'b0;
    checks++;
    if (cyc !== 11) begin
      errs++;
      $display("FAIL %s done_cycle: got %0d required 11", name, cyc);
    end
    checks++;
    if (nidle !== 0) begin
      errs++;
      $display("FAIL %s busy_held: got %0d idle cycles required 0", name, nidle);
    end
    checks++;
    if (nacc !== 6) begin
      errs++;
      $display("FAIL %s acc_cycles: got %0d required 6", name, nacc);
    end
    if (chain) start0 = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (done0 !== 1'b0 || busy0 !== 1'b0) begin
      errs++;
      $display("FAIL %s done_fall: got done=%0b busy=%0b required 0 0", name, done0, busy0);
    end
    checks++;
    if (rq.size() != 0 || wa_q.size() != 0) begin
      errs++;
      $display("FAIL %s pending: got %0d reads %0d writes outstanding required 0 0",
               name, rq.size(), wa_q.size());
    end
    if (chain) begin
      @(posedge clk); #1;
      start0 = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start0 = 1'b0;
    start1 = 1'b0;
    #1;
    checks++;
    if ({ren0, raddr0, acc0, wen0, waddr0} !== 15'd0) begin
      errs++;
      $display("FAIL reset_datapath: got %h required 0", {ren0, raddr0, acc0, wen0, waddr0});
    end
    checks++;
    if ({busy0, done0, busy1, done1} !== 4'd0) begin
      errs++;
      $display("FAIL reset_status: got %b required 0000", {busy0, done0, busy1, done1});
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy0, ren0, busy1, ren1} !== 4'd0) begin
      errs++;
      $display("FAIL release_not_start: got %b required 0000", {busy0, ren0, busy1, ren1});
    end
  endtask

  task automatic test_sequence();
    do_start0();
    run_check("seq", 0, 1'b0);
  endtask

  task automatic test_busy_start();
    do_start0();
    run_check("busy_start", 4, 1'b0);
  endtask

  task automatic test_back_to_back();
    do_start0();
    run_check("b2b_first", 0, 1'b1);
    run_check("b2b_second", 0, 1'b0);
  endtask

  task automatic test_reset_mid();
    rq.push_back(0);
    rq.push_back(2);
    rq.push_back(4);
    rq.push_back(1);
    wa_q.push_back(0);
    wd_q.push_back(7);
    do_start0();
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (ren0 !== 1'b1 || raddr0 !== 8'd3) begin
      errs++;
      $display("FAIL mid_position: got ren=%0b raddr=%0d required 1 3", ren0, raddr0);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({ren0, raddr0, acc0, wen0, waddr0, busy0, done0} !== 17'd0) begin
      errs++;
      $display("FAIL mid_async_clear: got %h required 0",
               {ren0, raddr0, acc0, wen0, waddr0, busy0, done0});
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if (busy0 !== 1'b0 || rq.size() != 0 || wa_q.size() != 0) begin
      errs++;
      $display("FAIL mid_abandon: got busy=%0b reads=%0d writes=%0d required 0 0 0",
               busy0, rq.size(), wa_q.size());
    end
    do_start0();
    run_check("after_reset", 0, 1'b0);
  endtask

  task automatic test_num_acc1();
    int cyc, nacc, nw, nr;
    cyc = 1;
    nacc = 0;
    nw = 0;
    nr = 0;
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    while (!done1 && cyc < 40) begin
      if (acc1) nacc++;
      if (ren1) begin
        checks++;
        if (raddr1 !== 8'(nr)) begin
          errs++;
          $display("FAIL acc1_raddr: got %0d required %0d", raddr1, nr);
        end
        nr++;
      end
      if (wen1) begin
        checks++;
        if (waddr1 !== 4'(nw) || ren1 !== 1'b0) begin
          errs++;
          $display("FAIL acc1_waddr: got %0d ren=%0b required %0d ren=0", waddr1, ren1, nw);
        end
        nw++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (cyc !== 13) begin
      errs++;
      $display("FAIL acc1_done_cycle: got %0d required 13", cyc);
    end
    checks++;
    if (nacc !== 4 || nw !== 4 || nr !== 4) begin
      errs++;
      $display("FAIL acc1_counts: got acc=%0d wen=%0d ren=%0d required 4 4 4", nacc, nw, nr);
    end
    @(posedge clk); #1;
    checks++;
    if (done1 !== 1'b0 || busy1 !== 1'b0) begin
      errs++;
      $display("FAIL acc1_done_fall: got done=%0b busy=%0b required 0 0", done1, busy1);
    end
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_busy_start();
    test_back_to_back();
    test_reset_mid();
    test_num_acc1();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
